// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: load-use, taken branch,
// multi-cycle data-memory wait with timeout, and a saturating stall counter.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   id_rs, id_rt, id_uses_rt   source registers of the instruction in ID
//   ex_memtoreg, ex_regwrite,
//   ex_writereg                load/destination info of the instruction in EX
//   branch_taken               branch resolved taken this cycle
//   mem_req, mem_ready         data-memory access request / completion
//   pc_le .. mem_wb_le         pipeline register load enables
//   if_id_flush, id_ex_bubble  squash controls for IF_ID and ID_EX
//   halted, mem_err            sticky halt and one-cycle timeout pulse
//   stall_cnt                  saturating count of cycles with pc_le=0
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memtoreg,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_writereg,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_le,
    output logic             if_id_le,
    output logic             id_ex_le,
    output logic             ex_mem_le,
    output logic             mem_wb_le,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_cnt_nxt;
    logic          timeout;
    logic          load_use;
    logic          mem_miss;
    logic          release_ok;

    assign load_use = ex_memtoreg & ex_regwrite & (ex_writereg != 5'd0)
                    & ((ex_writereg == id_rs)
                       | (id_uses_rt & (ex_writereg == id_rt)));

    assign mem_miss = mem_req & ~mem_ready;

    // Cycles in which the hazard priority list (branch / load-use / run)
    // decides the outputs: RUN without a memory miss, or the MEM_WAIT
    // cycle in which the access completes.
    assign release_ok = ((state == RUN) & ~mem_miss)
                      | ((state == MEM_WAIT) & mem_ready);

    assign timeout = (state == MEM_WAIT) & ~mem_ready
                   & (wait_cnt == WW'(MEM_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            RUN: begin
                if (mem_miss) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (timeout) begin
                    state_nxt    = HALT;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + WW'(1);
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        pc_le        = 1'b0;
        if_id_le     = 1'b0;
        id_ex_le     = 1'b0;
        ex_mem_le    = 1'b0;
        mem_wb_le    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (release_ok) begin
            id_ex_le  = 1'b1;
            ex_mem_le = 1'b1;
            mem_wb_le = 1'b1;
            if (branch_taken) begin
                // The ID instruction is discarded, so a load-use on it is moot.
                pc_le        = 1'b1;
                if_id_le     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                id_ex_bubble = 1'b1;
            end else begin
                pc_le    = 1'b1;
                if_id_le = 1'b1;
            end
        end
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_err   <= 1'b0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            mem_err <= timeout;
            if (timeout)
                halted <= 1'b1;
            if (!pc_le && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
